// File: rtl/tsc_capture_ctrl_if.sv
// Bundles the ADC request handshake and the readout stream of tsc_capture_ctrl.
// The master modport is the controller's view; slave is the ADC/consumer side.
interface tsc_capture_ctrl_if #(
    parameter int DW = 16
);
    logic          adc_req;
    logic          adc_rdy;
    logic [DW-1:0] adc_dat;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_dat;
    logic          out_last;

    modport master (
        output adc_req,
        input  adc_rdy,
        input  adc_dat,
        output out_valid,
        output out_dat,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  adc_req,
        output adc_rdy,
        output adc_dat,
        input  out_valid,
        input  out_dat,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/tsc_capture_ctrl.sv
// Paced ADC sampler with a circular pre/post-trigger buffer.
// After a rising threshold crossing it captures one window and streams it out.
module tsc_capture_ctrl #(
    parameter int DW      = 16,
    parameter int DEPTH   = 64,
    parameter int PRE     = 16,
    parameter int DIV     = 100,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [DW-1:0] thresh_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          timeout_err_o,
    output logic          overrun_err_o,
    tsc_capture_ctrl_if.master bus
);
    // state   | meaning
    // S_IDLE  | waiting for start
    // S_FILL  | collecting the first PRE samples
    // S_ARMED | buffer wraps, watching for a rising crossing
    // S_POST  | collecting post-trigger samples
    // S_READ  | streaming the window out, oldest first
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_READ} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(DIV);
    localparam int RW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(DEPTH + 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          req_q, req_d;
    logic [RW-1:0] req_cnt_q, req_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] trig_ptr_q, trig_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] prev_q, prev_d;
    logic          timeout_err_q, timeout_err_d;
    logic          overrun_err_q, overrun_err_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [DW-1:0] out_dat_q, out_dat_d;
    logic          rdy_meta_q, rdy_s_q;
    logic [DW-1:0] mem_q [DEPTH];

    logic          sampling, tick, acc, go_read;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        req_d         = req_q;
        req_cnt_d     = req_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        trig_ptr_d    = trig_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        rd_cnt_d      = rd_cnt_q;
        cnt_d         = cnt_q;
        prev_d        = prev_q;
        timeout_err_d = timeout_err_q;
        overrun_err_d = overrun_err_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_dat_d     = out_dat_q;
        tick          = 1'b0;
        acc           = 1'b0;
        go_read       = 1'b0;
        sampling      = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);

        if (sampling) begin
            if (tick_cnt_q == '0) begin
                tick       = 1'b1;
                tick_cnt_d = TW'(DIV - 1);
            end else begin
                tick_cnt_d = tick_cnt_q - 1'b1;
            end
            if (req_q) begin
                if ((req_cnt_q >= RW'(SETTLE)) && rdy_s_q) begin
                    acc   = 1'b1;
                    req_d = 1'b0;
                end else if (req_cnt_q == RW'(TIMEOUT)) begin
                    req_d         = 1'b0;
                    timeout_err_d = 1'b1;
                end else begin
                    req_cnt_d = req_cnt_q + 1'b1;
                end
                if (tick) overrun_err_d = 1'b1;
            end else if (tick) begin
                req_d     = 1'b1;
                req_cnt_d = RW'(1);
            end
        end

        if (acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            prev_d   = bus.adc_dat;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    timeout_err_d = 1'b0;
                    overrun_err_d = 1'b0;
                    wr_ptr_d      = '0;
                    cnt_d         = '0;
                    tick_cnt_d    = TW'(DIV - 1);
                    state_d       = S_FILL;
                end
            end
            S_FILL: begin
                if (acc) begin
                    if (cnt_inc == CW'(PRE)) begin
                        cnt_d   = '0;
                        state_d = S_ARMED;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_ARMED: begin
                // FILL always precedes ARMED, so prev_q is a real sample here
                if (acc && (prev_q < thresh_i) && (thresh_i <= bus.adc_dat)) begin
                    trig_ptr_d = wr_ptr_q;
                    cnt_d      = CW'(1);
                    if (DEPTH - PRE == 1) go_read = 1'b1;
                    else                  state_d = S_POST;
                end
            end
            S_POST: begin
                if (acc) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(DEPTH - PRE)) go_read = 1'b1;
                end
            end
            S_READ: begin
                // Prefetch the next word whenever the output register is free
                if (!out_valid_q || (bus.out_ready && !out_last_q)) begin
                    out_dat_d   = mem_q[rd_ptr_q];
                    out_last_d  = (rd_cnt_q == PW'(DEPTH - 1));
                    out_valid_d = 1'b1;
                    rd_ptr_d    = rd_ptr_q + 1'b1;
                    rd_cnt_d    = rd_cnt_q + 1'b1;
                end else if (out_valid_q && bus.out_ready && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (go_read) begin
            state_d     = S_READ;
            req_d       = 1'b0;
            rd_ptr_d    = trig_ptr_d - PW'(PRE);
            rd_cnt_d    = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            tick_cnt_q    <= '0;
            req_q         <= 1'b0;
            req_cnt_q     <= '0;
            wr_ptr_q      <= '0;
            trig_ptr_q    <= '0;
            rd_ptr_q      <= '0;
            rd_cnt_q      <= '0;
            cnt_q         <= '0;
            prev_q        <= '0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_dat_q     <= '0;
            rdy_meta_q    <= 1'b0;
            rdy_s_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            req_q         <= req_d;
            req_cnt_q     <= req_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            trig_ptr_q    <= trig_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rd_cnt_q      <= rd_cnt_d;
            cnt_q         <= cnt_d;
            prev_q        <= prev_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_dat_q     <= out_dat_d;
            rdy_meta_q    <= bus.adc_rdy;
            rdy_s_q       <= rdy_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) mem_q[wr_ptr_q] <= bus.adc_dat;
    end

    assign bus.adc_req   = req_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_dat   = out_dat_q;
    assign bus.out_last  = out_last_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_READ);
    assign timeout_err_o = timeout_err_q;
    assign overrun_err_o = overrun_err_q;
endmodule
